invmat_loader: RTL

INVMAT_LOADER -- requirements
Module: invmat_loader

---
 rtl/invmat_pkg.sv | 16 +
 rtl/invmat_loader.sv | 112 +++++++++++
 2 files changed

// File: rtl/invmat_pkg.sv
// Shared definitions for the inverse-matrix input loader: default matrix
// geometry and the loader FSM state encoding.
package invmat_pkg;

  localparam int MAT_SIZE_DEF   = 5;   // N: matrix is N x N
  localparam int MAT_DWIDTH_DEF = 46;  // signed <31.14> fixed-point element

  // FILL: accepting elements; HOLD: full matrix waiting for the inverter;
  // LAUNCH: single-cycle hand-off strobe.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HOLD   = 2'd1,
    LAUNCH = 2'd2
  } state_t;

endpackage

// File: rtl/invmat_loader.sv
// Collects a row-major stream of N*N elements into a register buffer and
// launches the whole matrix to the inverter with a one-cycle strobe once the
// inverter reports idle. Malformed frames are dropped with a frame_err pulse.
//
// Handshake: an element transfers on a rising edge where s_vld & s_rdy.
// s_rdy depends on FSM state only (high iff FILL), never on s_vld, so the
// upstream may hold s_vld high while waiting. mat_vld is a one-cycle strobe
// with no back-pressure; inv_ready is only looked at in HOLD.
module invmat_loader
  import invmat_pkg::*;
#(
  parameter int MAT_SIZE   = MAT_SIZE_DEF,
  parameter int MAT_DWIDTH = MAT_DWIDTH_DEF
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [MAT_DWIDTH-1:0]                    s_data,
  input  logic                                     s_vld,
  input  logic                                     s_last,
  output logic                                     s_rdy,
  input  logic                                     inv_ready,
  output logic [MAT_DWIDTH*MAT_SIZE*MAT_SIZE-1:0]  mat_in,
  output logic                                     mat_vld,
  output logic                                     frame_err,
  output logic [7:0]                               mat_cnt,
  output state_t                                   state_dbg
);

  localparam int NELEM = MAT_SIZE * MAT_SIZE;
  localparam int IDX_W = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NELEM - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  frame_err_q, frame_err_d;
  logic [7:0]            mat_cnt_q, mat_cnt_d;
  logic                  xfer;
  logic [MAT_DWIDTH-1:0] buf_q [NELEM];

  // Next-state, index, error and launch-count decode.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_err_d = 1'b0;
    mat_cnt_d   = mat_cnt_q;
    s_rdy       = 1'b0;
    xfer        = 1'b0;
    case (state_q)
      FILL: begin
        s_rdy = 1'b1;
        xfer  = s_vld;
        if (s_vld) begin
          if (idx_q == IDX_LAST) begin
            // Slot N*N-1 written: complete frame only if marked last.
            idx_d = '0;
            if (s_last) state_d = HOLD;
            else        frame_err_d = 1'b1;
          end else if (s_last) begin
            // Early last: drop the partial matrix.
            idx_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (inv_ready) state_d = LAUNCH;
      end
      LAUNCH: begin
        mat_cnt_d = mat_cnt_q + 8'd1;
        state_d   = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // Control registers: state, write index, error pulse, launch counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      idx_q       <= '0;
      frame_err_q <= 1'b0;
      mat_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_err_q <= frame_err_d;
      mat_cnt_q   <= mat_cnt_d;
    end
  end

  // Element buffer: one register per matrix slot, written bit-exact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NELEM; k++) buf_q[k] <= '0;
    end else if (xfer) begin
      buf_q[idx_q] <= s_data;
    end
  end

  // Element (r,c) sits at bit offset MAT_DWIDTH*(N*r+c).
  for (genvar k = 0; k < NELEM; k++) begin : g_pack
    assign mat_in[k*MAT_DWIDTH +: MAT_DWIDTH] = buf_q[k];
  end

  assign mat_vld   = (state_q == LAUNCH);
  assign frame_err = frame_err_q;
  assign mat_cnt   = mat_cnt_q;
  assign state_dbg = state_q;

endmodule
